// File: rtl/logic_unit_pkg.sv
// Shared encodings for the pipelined bitwise logic unit: op codes, FSM states
// and the accumulate-op helper.
package logic_unit_pkg;

    localparam logic [2:0] OP_OR      = 3'b000;
    localparam logic [2:0] OP_AND     = 3'b001;
    localparam logic [2:0] OP_XOR     = 3'b010;
    localparam logic [2:0] OP_NOR     = 3'b011;
    localparam logic [2:0] OP_ANDN    = 3'b100;
    localparam logic [2:0] OP_PASSB   = 3'b101;
    localparam logic [2:0] OP_ACC_OR  = 3'b110;
    localparam logic [2:0] OP_ACC_XOR = 3'b111;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ACC  = 1'b1;

    function automatic logic is_acc_op(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/logic_unit_alu.sv
// Combinational bitwise ALU; the accumulate codes fold as plain OR / XOR so the
// same block serves fresh beats and accumulate steps.
module logic_unit_alu #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] res
);
    import logic_unit_pkg::*;

    // NOTE: a default assignment ahead of the case keeps always_comb latch-free.
    always_comb begin
        res = '0;
        case (op)
            OP_OR:      res = x | y;
            OP_AND:     res = x & y;
            OP_XOR:     res = x ^ y;
            OP_NOR:     res = ~(x | y);
            OP_ANDN:    res = x & ~y;
            OP_PASSB:   res = y;
            OP_ACC_OR:  res = x | y;
            OP_ACC_XOR: res = x ^ y;
            default:    res = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with OR/XOR burst accumulation and a one-entry
// output register. Define LOGIC_UNIT_REDUCE_EN for registered reduction outputs.
module logic_unit_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
`ifdef LOGIC_UNIT_REDUCE_EN
    ,
    output logic             out_red_or,
    output logic             out_red_and,
    output logic             out_red_xor
`endif
);
    import logic_unit_pkg::*;

    logic [0:0]       state;
    logic             acc_xor;
    logic [WIDTH-1:0] acc;

    logic             accept;
    logic             take;
    logic             in_acc;
    logic             load;
    logic [WIDTH-1:0] alu_x;
    logic [WIDTH-1:0] alu_y;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_res;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign take     = out_valid && out_ready;
    assign in_acc   = (state == ST_ACC);

    // Mid-burst the ALU folds the next A into acc under the latched op; in_op and in_b are ignored.
    assign alu_x  = in_acc ? acc : in_a;
    assign alu_y  = in_acc ? in_a : in_b;
    assign alu_op = in_acc ? (acc_xor ? OP_ACC_XOR : OP_ACC_OR) : in_op;

    assign load = accept && (in_acc ? in_last : (!is_acc_op(in_op) || in_last));

    logic_unit_alu #(.WIDTH(WIDTH)) u_alu (
        .x   (alu_x),
        .y   (alu_y),
        .op  (alu_op),
        .res (alu_res)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            acc     <= '0;
            acc_xor <= 1'b0;
        end else if (accept) begin
            if (in_acc) begin
                if (in_last) begin
                    state <= ST_IDLE;
                    acc   <= '0;
                end else begin
                    acc <= alu_res;
                end
            end else if (is_acc_op(in_op) && !in_last) begin
                state   <= ST_ACC;
                acc     <= alu_res;
                acc_xor <= in_op[0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_zero  <= 1'b1;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= alu_res;
            out_zero  <= (alu_res == '0);
        end else if (take) begin
            out_valid <= 1'b0;
        end
    end

`ifdef LOGIC_UNIT_REDUCE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_red_or  <= 1'b0;
            out_red_and <= 1'b0;
            out_red_xor <= 1'b0;
        end else if (load) begin
            out_red_or  <= |alu_res;
            out_red_and <= &alu_res;
            out_red_xor <= ^alu_res;
        end
    end
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: vector table, directed corner sequences
// and randomized traffic against a beat-level reference model.
module tb_logic_unit_pipe;
    import logic_unit_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [2:0]   in_op;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_zero;
`ifdef LOGIC_UNIT_REDUCE_EN
    logic         out_red_or;
    logic         out_red_and;
    logic         out_red_xor;
`endif

    logic_unit_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero)
`ifdef LOGIC_UNIT_REDUCE_EN
        ,
        .out_red_or  (out_red_or),
        .out_red_and (out_red_and),
        .out_red_xor (out_red_xor)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: pending output slot plus an in-progress burst fold.
    bit         m_valid;
    logic [W-1:0] m_data;
    bit         m_burst;
    logic [2:0] m_bop;
    logic [W-1:0] m_acc;

    function automatic logic [W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] x,
                                            input logic [W-1:0] y);
        case (op)
            3'd0:    return x | y;
            3'd1:    return x & y;
            3'd2:    return x ^ y;
            3'd3:    return ~(x | y);
            3'd4:    return x & ~y;
            3'd5:    return y;
            3'd6:    return x | y;
            default: return x ^ y;
        endcase
    endfunction

    task automatic model_clear();
        m_valid = 0;
        m_data  = '0;
        m_burst = 0;
        m_bop   = 3'd0;
        m_acc   = '0;
    endtask

    // One clock: drive a beat, predict, step the edge, compare.
    task automatic cycle(input bit v, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit last, input bit rdy);
        bit           acc_ok;
        bit           ld;
        logic [W-1:0] res;
        in_valid  = v;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_last   = last;
        out_ready = rdy;
        #1;
        check("in_ready", {31'd0, in_ready}, {31'd0, (!m_valid || rdy)});
        acc_ok = v && (!m_valid || rdy);
        ld  = 0;
        res = '0;
        if (acc_ok) begin
            if (!m_burst) begin
                if (op >= 3'd6 && !last) begin
                    m_burst = 1;
                    m_bop   = op;
                    m_acc   = ref_op(op, a, b);
                end else begin
                    res = ref_op(op, a, b);
                    ld  = 1;
                end
            end else begin
                res = ref_op(m_bop, m_acc, a);
                if (last) begin
                    ld      = 1;
                    m_burst = 0;
                    m_acc   = '0;
                end else begin
                    m_acc = res;
                end
            end
        end
        if (ld) begin
            m_valid = 1;
            m_data  = res;
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
        check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        if (m_valid) begin
            check("out_data", {16'd0, out_data}, {16'd0, m_data});
            check("out_zero", {31'd0, out_zero}, {31'd0, (m_data == '0)});
`ifdef LOGIC_UNIT_REDUCE_EN
            check("out_red_or",  {31'd0, out_red_or},  {31'd0, (m_data != '0)});
            check("out_red_and", {31'd0, out_red_and}, {31'd0, (m_data == '1)});
            check("out_red_xor", {31'd0, out_red_xor}, {31'd0, ^m_data});
`endif
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #2;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_zero",  {31'd0, out_zero},  32'd1);
        check("rst_out_data",  {16'd0, out_data},  32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
`ifdef LOGIC_UNIT_REDUCE_EN
        check("rst_red", {29'd0, out_red_or, out_red_and, out_red_xor}, 32'd0);
`endif
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit           last;
        logic [W-1:0] exp_data;
        bit           exp_zero;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{OP_OR,     16'h1234, 16'h00FF, 1'b0, 16'h12FF, 1'b0};
        vecs[1] = '{OP_AND,    16'h1234, 16'h00FF, 1'b0, 16'h0034, 1'b0};
        vecs[2] = '{OP_XOR,    16'h1234, 16'h00FF, 1'b0, 16'h12CB, 1'b0};
        vecs[3] = '{OP_NOR,    16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b1};
        vecs[4] = '{OP_ANDN,   16'hFF00, 16'h0F00, 1'b0, 16'hF000, 1'b0};
        vecs[5] = '{OP_PASSB,  16'h5555, 16'hBEEF, 1'b1, 16'hBEEF, 1'b0};
        vecs[6] = '{OP_ACC_OR, 16'h8000, 16'h0001, 1'b1, 16'h8001, 1'b0};
        vecs[7] = '{OP_OR,     16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0};

        in_valid = 0; in_a = '0; in_b = '0; in_op = 3'd0; in_last = 0; out_ready = 1;
        rst_n = 1'b1;
        #3;
        do_reset();

        // Reset mid-burst discards the partial accumulation.
        cycle(1, OP_ACC_OR, 16'h00F0, 16'h0000, 0, 1);
        do_reset();
        cycle(1, OP_ACC_OR, 16'h0001, 16'h0000, 1, 1);
        check("post_reset_acc", {16'd0, out_data}, 32'h0001);
        cycle(0, OP_OR, '0, '0, 0, 1);

        // Back-to-back streaming, one result per cycle.
        for (int i = 0; i < 8; i++) begin
            cycle(1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].last, 1);
            check($sformatf("vec%0d_data", i), {16'd0, out_data}, {16'd0, vecs[i].exp_data});
            check($sformatf("vec%0d_zero", i), {31'd0, out_zero}, {31'd0, vecs[i].exp_zero});
        end
        cycle(0, OP_OR, '0, '0, 0, 1);

        // Backpressure holds the result, then take+load in the same edge.
        cycle(1, OP_OR, 16'h1234, 16'h00FF, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, OP_XOR, 16'hFFFF, 16'h0F0F, 0, 0);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_hold", {16'd0, out_data}, 32'h12FF);
        end
        cycle(1, OP_ANDN, 16'hFF00, 16'h0F00, 0, 1);
        check("bp_reload_data",  {16'd0, out_data},  32'hF000);
        check("bp_reload_valid", {31'd0, out_valid}, 32'd1);
        cycle(0, OP_OR, '0, '0, 0, 1);

        // ACC_XOR burst; in_op changes mid-burst must be ignored.
        cycle(1, OP_ACC_XOR, 16'h000F, 16'h00F0, 0, 1);
        check("burst_nv1", {31'd0, out_valid}, 32'd0);
        cycle(1, OP_OR, 16'h0FF0, 16'hFFFF, 0, 1);
        check("burst_nv2", {31'd0, out_valid}, 32'd0);
        cycle(1, OP_OR, 16'h1111, 16'hFFFF, 1, 1);
        check("burst_result", {16'd0, out_data}, 32'h1E1E);
        cycle(0, OP_OR, '0, '0, 0, 1);
        check("burst_drained", {31'd0, out_valid}, 32'd0);

`ifdef LOGIC_UNIT_REDUCE_EN
        cycle(1, OP_XOR, 16'h00A5, 16'h0000, 0, 1);
        check("red_vec", {29'd0, out_red_or, out_red_and, out_red_xor}, 32'b100);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), W'($urandom),
                  W'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);
        end
        cycle(1, OP_ACC_OR, 16'h0000, 16'h0000, 1, 1);
        cycle(0, OP_OR, '0, '0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
Parametrised, registered bitwise logic unit. It replaces fixed-width combinational OR/AND-style helpers in the execute path.
- Supports WIDTH-bit operands and six bitwise ops.
- Adds multi-beat accumulate modes (OR/XOR across a burst).
- Valid/ready handshake on input and output; one-entry output register with backpressure.

Parameters:
WIDTH, 16, operand/result width in bits (>=2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low (one clock domain; polarity and synchronicity fixed)
in_valid  input  1  input beat present
in_ready  output  1  unit can accept a beat this cycle
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_op  input  3  operation select (encoding below)
in_last  input  1  final beat of an accumulate burst; ignored for non-accumulate ops
out_valid  output  1  result held in out_data
out_ready  input  1  consumer takes result this cycle
out_data  output  WIDTH  registered result
out_zero  output  1  registered, high when out_data == 0

Behaviour:
- Op encoding:
  - 000 OR (A|B)
  - 001 AND
  - 010 XOR
  - 011 NOR
  - 100 ANDN (A & ~B)
  - 101 PASSB
  - 110 ACC_OR
  - 111 ACC_XOR
- Handshake:
  - A beat is accepted when in_valid && in_ready.
  - A result is taken when out_valid && out_ready.
  - in_ready = !out_valid || out_ready, combinational. Full throughput with back-to-back beats when out_ready stays high.
- Output register:
  - out_valid rises the cycle after a result-producing beat is accepted (latency 1).
  - out_valid falls after the result is taken unless a new result loads in the same cycle.
  - out_data and out_zero stay stable while out_valid && !out_ready.
- FSM states: IDLE, ACC.
  - IDLE, non-accumulate op accepted: result = A op B → output register; stay IDLE.
  - IDLE, ACC_* accepted with in_last=0: acc <= A|B (ACC_OR) or A^B (ACC_XOR); latch op; go to ACC. No output.
  - IDLE, ACC_* accepted with in_last=1: single-beat burst; output A op B; stay IDLE.
  - ACC, beat accepted: acc_next = acc op in_a (in_b ignored).
    - in_last=0: acc <= acc_next; stay ACC.
    - in_last=1: output acc_next, clear acc; go to IDLE.
  - In ACC, in_op is ignored; the latched op governs the whole burst.
- Width rules: all ops are purely bitwise; no carries. WIDTH applies uniformly to every bus.
- Reset, asynchronous assert:
  - out_valid=0, out_data=0, out_zero=1, acc=0, state=IDLE.
  - Any mid-burst accumulation or pending output is discarded.
- Simultaneous take+load: new result replaces the old one in the same edge; out_valid stays 1.
- in_valid low: no state change; the held result persists.

Optional Feature:
LOGIC_UNIT_REDUCE_EN
- Defined: adds three outputs, each 1 bit and registered with out_data:
  - out_red_or = |result
  - out_red_and = &result
  - out_red_xor = ^result
  - Reset values: 0, 0, 0.
- Undefined: these ports and their flops are absent; all other behaviour is identical.

Decomposition:
- Package logic_unit_pkg holds:
  - op encoding constants (OP_OR … OP_ACC_XOR)
  - FSM state encoding (ST_IDLE, ST_ACC)
  - helper is_acc_op(op)
- One natural sub-module: logic_unit_alu, a combinational WIDTH-param block that computes x op y for all six bitwise ops. It is instantiated once for both fresh beats and accumulate steps. logic_unit_pipe owns the FSM, acc register and output register.

Test Plan:
- Reset mid-burst: ACC_OR beat A=0x00F0 (last=0), assert rst_n=0 → out_valid=0, out_zero=1, state IDLE. Next ACC_OR beat A=0x0001 B=0 last=1 → out_data=0x0001.
- Streaming ops, out_ready=1, WIDTH=16: OR 0x1234|0x00FF → 0x12FF; AND → 0x0034; XOR → 0x12CB; NOR 0xFFFF,0 → 0x0000 with out_zero=1. One result per cycle, latency 1.
- Backpressure: OR beat accepted, out_ready=0 for 3 cycles → in_ready=0, out_data held at 0x12FF. out_ready=1 with a new ANDN 0xFF00,0x0F00 beat → out_data=0xF000, out_valid stays 1.
- ACC_XOR burst: beats A=0x000F/B=0x00F0, then A=0x0FF0, then A=0x1111 last=1 → one output 0x1E1E. No out_valid before the last beat; in_op changed to OR mid-burst is ignored.
- Single-beat ACC_OR: A=0x8000 B=0x0001 last=1 → out_data=0x8001 next cycle, FSM stays IDLE.
- LOGIC_UNIT_REDUCE_EN, WIDTH=8: XOR 0xA5,0x00 → out_red_or=1, out_red_and=0, out_red_xor=0.
